// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: sequences the I2S receiver and packs a mono sample stream into double-banked frames.
module i2s_capture_ctrl #(
    parameter int DATA_BITS     = 16,
    parameter int FRAME_LOG2    = 8,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic [1:0]               ch_sel_i,
    output logic                     i2s_get_o,
    input  logic                     i2s_done_i,
    input  logic [DATA_BITS-1:0]     i2s_sample_data_L_i,
    input  logic [DATA_BITS-1:0]     i2s_sample_data_R_i,
    output logic                     buf_wr_en_o,
    output logic [FRAME_LOG2:0]      buf_wr_addr_o,
    output logic [DATA_BITS-1:0]     buf_wr_data_o,
    output logic                     frame_valid_o,
    output logic                     frame_bank_o,
    input  logic                     frame_ack_i,
    output logic                     overrun_o,
    output logic [DROP_CNT_BITS-1:0] drop_cnt_o
);
    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;
    state_t                state;
    logic                  sync1, sync2, sync3, done_evt;
    logic                  wr_bank, frame_done, valid_after_ack;
    logic [FRAME_LOG2-1:0] idx;
    logic [1:0]            ch_lat, ch_eff;
    logic [DATA_BITS:0]    mix_sum;
    logic [DATA_BITS-1:0]  sample;
    always_comb begin
        done_evt        = sync2 & ~sync3;
        ch_eff          = (idx == '0) ? ch_sel_i : ch_lat;
        mix_sum         = {i2s_sample_data_L_i[DATA_BITS-1], i2s_sample_data_L_i} +
                          {i2s_sample_data_R_i[DATA_BITS-1], i2s_sample_data_R_i};
        // floor((L+R)/2): drop the LSB of the sign-extended sum
        sample          = (ch_eff == 2'b01) ? i2s_sample_data_R_i :
                          (ch_eff == 2'b10) ? mix_sum[DATA_BITS:1] : i2s_sample_data_L_i;
        frame_done      = buf_wr_en_o & (&buf_wr_addr_o[FRAME_LOG2-1:0]);
        valid_after_ack = frame_valid_o & ~frame_ack_i;
    end
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            {sync3, sync2, sync1} <= 3'b000;
            wr_bank       <= 1'b0;
            idx           <= '0;
            ch_lat        <= 2'b00;
            i2s_get_o     <= 1'b0;
            buf_wr_en_o   <= 1'b0;
            buf_wr_addr_o <= '0;
            buf_wr_data_o <= '0;
            frame_valid_o <= 1'b0;
            frame_bank_o  <= 1'b0;
            overrun_o     <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            {sync3, sync2, sync1} <= {sync2, sync1, i2s_done_i};
            buf_wr_en_o <= 1'b0;
            // ack is taken before the completing write decides publish vs drop
            if (frame_done && !valid_after_ack) begin
                frame_valid_o <= 1'b1;
                frame_bank_o  <= wr_bank;
                wr_bank       <= ~wr_bank;
            end else begin
                frame_valid_o <= valid_after_ack;
                if (frame_done) begin
                    overrun_o <= 1'b1;
                    if (!(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
                end
            end
            if (state != IDLE && !enable_i) begin
                state     <= IDLE;
                i2s_get_o <= 1'b0;
                idx       <= '0;
            end else if (state == IDLE) begin
                if (enable_i) begin
                    state      <= SYNC;
                    i2s_get_o  <= 1'b1;
                    overrun_o  <= 1'b0;
                    drop_cnt_o <= '0;
                    idx        <= '0;
                end
            end else if (done_evt) begin
                if (state == SYNC) begin
                    state <= CAPTURE;
                    idx   <= '0;
                end else begin
                    buf_wr_en_o   <= 1'b1;
                    buf_wr_addr_o <= {wr_bank, idx};
                    buf_wr_data_o <= sample;
                    idx           <= idx + 1'b1;
                    if (idx == '0) ch_lat <= ch_sel_i;
                end
            end
        end
    end
endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
- System-clock-domain sequencer for the I2S receiver.
- Drives the receiver's get input and detects its bclk-domain done pulse.
- Selects or mixes left and right samples into a mono stream.
- Writes the stream into a double-banked frame buffer and publishes full frames of 2^FRAME_LOG2 samples to the spectrum (FFT) engine with a valid/ack handshake, counting frames dropped when the consumer is slow.

Parameters:
- DATA_BITS, 16: sample width, matching the I2S receiver.
- FRAME_LOG2, 8: log2 of samples per frame (N = 2^FRAME_LOG2).
- DROP_CNT_BITS, 8: width of the saturating dropped-frame counter.

Ports:
- clk_i  in  1  system clock; frequency must be >= 8x codec bclk.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  level; 1 = capture continuously.
- ch_sel_i  in  2  00 = left, 01 = right, 10 = (L+R)/2, 11 = left.
- i2s_get_o  out  1  to I2S receiver get input.
- i2s_done_i  in  1  I2S receiver done pulse, bclk domain, asynchronous to clk_i.
- i2s_sample_data_L_i  in  DATA_BITS  left sample, signed.
- i2s_sample_data_R_i  in  DATA_BITS  right sample, signed.
- buf_wr_en_o  out  1  frame buffer write strobe.
- buf_wr_addr_o  out  FRAME_LOG2+1  {bank, index}.
- buf_wr_data_o  out  DATA_BITS  sample to write.
- frame_valid_o  out  1  a complete frame is ready.
- frame_bank_o  out  1  bank holding the ready frame.
- frame_ack_i  in  1  consumer has finished with the frame.
- overrun_o  out  1  sticky: at least one frame was dropped.
- drop_cnt_o  out  DROP_CNT_BITS  saturating count of dropped frames.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; write bank 0; index 0; synchronizer flops 0.
  - Reset mid-frame abandons the partial frame and any published frame.
- Done detection:
  - i2s_done_i passes through a 2-FF synchronizer plus one history flop.
  - done_evt = sync2 & ~sync3 (rising edge only); one event per bclk pulse.
- Sample latching:
  - On done_evt, L and R are sampled directly. They are stable for >=1 bclk after done, which the 8x clock ratio guarantees covers the sampling point.
  - Mix mode 10: sign-extend both to DATA_BITS+1, add, arithmetic shift right 1 (floor), truncate to DATA_BITS. Example: -1 + 0 gives -1.
- Write timing:
  - buf_wr_en_o is a one-cycle pulse in the cycle after done_evt.
  - addr = {wr_bank, idx}; data = the selected/mixed sample.
- FSM states:
  - IDLE: i2s_get_o=0. When enable_i=1: go to SYNC, set i2s_get_o=1, clear overrun_o and drop_cnt_o, idx=0.
  - SYNC: the first done_evt is discarded (the receiver's first frame after get is possibly partial). Then go to CAPTURE with idx=0.
  - CAPTURE:
    - Each done_evt writes one sample; idx increments and wraps modulo N.
    - ch_sel_i is latched whenever idx=0 is written; mid-frame changes take effect at the next frame.
    - On the write with idx=N-1 (frame complete):
      - If frame_valid_o=0 after this cycle's ack processing: next cycle frame_valid_o=1, frame_bank_o=wr_bank, and wr_bank toggles.
      - Otherwise: the frame is dropped, wr_bank is unchanged (the bank is rewritten), overrun_o=1, and drop_cnt_o increments, saturating at all-ones.
- enable_i=0 in any non-IDLE state:
  - Next cycle: IDLE, i2s_get_o=0.
  - The partial frame is discarded and idx returns to 0.
  - A pending frame_valid_o stays until acked.
- Handshake:
  - frame_ack_i while frame_valid_o=1 clears frame_valid_o next cycle.
  - Ack while not valid is ignored.
  - Ack and frame completion in the same cycle: the ack is processed first, the new frame is published (valid stays 1, bank switches), and no drop occurs.
- The bank being written is never the bank published by frame_valid_o.

Test Plan (FRAME_LOG2=2, N=4, clk_i = 16x bclk):
1. Reset, then enable_i=1, ch_sel=00, feed 5 done pulses with L=10,11,12,13,14 -> first discarded; writes addr 0..3 with data 11,12,13,14; frame_valid_o=1, frame_bank_o=0 one cycle after the 4th write; next writes go to addr 4+.
2. ch_sel=10, L=-1, R=0; L=0x7FFF, R=0x7FFF; L=-32768, R=-32768 -> data = -1 (0xFFFF), 0x7FFF, 0x8000.
3. Never ack; capture 3 frames -> frame 1 published in bank 0; frames 2 and 3 dropped in bank 1; overrun_o=1, drop_cnt_o=2, frame_bank_o stays 0.
4. Ack asserted in the same cycle as the 4th write of frame 2 -> frame_valid_o stays 1, frame_bank_o 0 -> 1, drop_cnt_o=0.
5. Drop enable_i after 2 writes -> i2s_get_o=0 next cycle; re-enable -> first done discarded; writes restart at idx 0 of the same bank; overrun/drop cleared.
6. Assert rst_n=0 mid-frame with frame_valid_o=1 -> all outputs 0 immediately (async); an i2s_done_i pulse during reset produces no write.
